// File: rtl/accumulate_dbx.sv
// Pushbutton accumulator: synchronised, debounced press adds or subtracts Data
// into a wrapping or saturating running total with sticky overflow and Done pulse.
module accumulate_dbx #(
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_ACC = 10,
    parameter int DEBOUNCE  = 4,
    parameter int SATURATE  = 0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Enable_n,
    input  logic                 Clear,
    input  logic                 Sub,
    input  logic [WIDTH_IN-1:0]  Data,
    output logic [WIDTH_ACC-1:0] Acc,
    output logic                 Overflow,
    output logic                 Done
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic                 s1;
    logic                 s2;
    logic                 deb;
    logic [CNT_W-1:0]     cnt;
    logic                 flip;
    logic                 press;
    logic [WIDTH_ACC:0]   d_ext;
    logic [WIDTH_ACC:0]   sum;
    logic [WIDTH_ACC:0]   diff;
    logic [WIDTH_ACC:0]   t;
    logic                 ovf_now;
    logic [WIDTH_ACC-1:0] acc_next;

    // Wrap keeps the low bits; saturation clamps toward the side that overflowed.
    function automatic logic [WIDTH_ACC-1:0] limit(input logic [WIDTH_ACC:0] val,
                                                   input logic ovf,
                                                   input logic sub);
        if (ovf && (SATURATE != 0))
            return sub ? '0 : '1;
        return val[WIDTH_ACC-1:0];
    endfunction

    // The extra top bit is the carry for add and the borrow for subtract.
    always_comb begin
        d_ext    = (WIDTH_ACC + 1)'(Data);
        sum      = {1'b0, Acc} + d_ext;
        diff     = {1'b0, Acc} - d_ext;
        t        = Sub ? diff : sum;
        ovf_now  = t[WIDTH_ACC];
        acc_next = limit(t, ovf_now, Sub);
        flip     = (s2 != deb) && (cnt == CNT_LAST);
        press    = flip && deb;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= Enable_n;
            s2 <= s1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            deb <= 1'b1;
            cnt <= '0;
        end else if (s2 == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            deb <= s2;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Clear wins over a coincident press; the debouncer above still consumes it.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Acc      <= '0;
            Overflow <= 1'b0;
            Done     <= 1'b0;
        end else if (Clear) begin
            Acc      <= '0;
            Overflow <= 1'b0;
            Done     <= 1'b0;
        end else if (press) begin
            Acc      <= acc_next;
            Overflow <= Overflow | ovf_now;
            Done     <= 1'b1;
        end else begin
            Done     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_accumulate_dbx.sv
// Bench for accumulate_dbx: wrapping and saturating instances share stimulus and
// are compared every cycle against an integer reference model.
module tb_accumulate_dbx;

    localparam int WI   = 8;
    localparam int WA   = 10;
    localparam int DB   = 4;
    localparam int MAXV = (1 << WA) - 1;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Enable_n;
    logic          Clear;
    logic          Sub;
    logic [WI-1:0] Data;
    logic [WA-1:0] acc_0, acc_1;
    logic          ovf_0, ovf_1;
    logic          done_0, done_1;

    accumulate_dbx #(.WIDTH_IN(WI), .WIDTH_ACC(WA), .DEBOUNCE(DB), .SATURATE(0)) u_dut_wrap (
        .Clock(Clock), .Reset(Reset), .Enable_n(Enable_n), .Clear(Clear), .Sub(Sub),
        .Data(Data), .Acc(acc_0), .Overflow(ovf_0), .Done(done_0)
    );

    accumulate_dbx #(.WIDTH_IN(WI), .WIDTH_ACC(WA), .DEBOUNCE(DB), .SATURATE(1)) u_dut_sat (
        .Clock(Clock), .Reset(Reset), .Enable_n(Enable_n), .Clear(Clear), .Sub(Sub),
        .Data(Data), .Acc(acc_1), .Overflow(ovf_1), .Done(done_1)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int done_count = 0;
    int last_done_cyc = -1;

    // Reference model: index 0 wraps, index 1 saturates.
    int m_acc [2];
    int m_ovf [2];
    int m_done;
    bit m_deb;
    bit sync_q [$];
    bit run_q  [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_acc[s] = 0;
            m_ovf[s] = 0;
        end
        m_done = 0;
        m_deb  = 1'b1;
        sync_q.delete();
        sync_q.push_back(1'b1);
        sync_q.push_back(1'b1);
        run_q.delete();
    endtask

    // A level is accepted once the last DB synchronised samples all disagree with it.
    task automatic model_edge();
        bit lvl;
        bit flip;
        bit press;
        int t;
        lvl = sync_q.pop_front();
        sync_q.push_back(Enable_n);
        run_q.push_back(lvl);
        if (run_q.size() > DB) void'(run_q.pop_front());
        flip = (run_q.size() == DB);
        foreach (run_q[i]) if (run_q[i] == m_deb) flip = 1'b0;
        press = flip && m_deb;
        if (flip) begin
            m_deb = !m_deb;
            run_q.delete();
        end
        if (Clear) begin
            for (int s = 0; s < 2; s++) begin
                m_acc[s] = 0;
                m_ovf[s] = 0;
            end
            m_done = 0;
        end else begin
            m_done = press ? 1 : 0;
            if (press) begin
                for (int s = 0; s < 2; s++) begin
                    t = Sub ? m_acc[s] - int'(Data) : m_acc[s] + int'(Data);
                    if (t < 0 || t > MAXV) begin
                        m_ovf[s] = 1;
                        if (s == 1) m_acc[s] = (t < 0) ? 0 : MAXV;
                        else        m_acc[s] = (t + MAXV + 1) % (MAXV + 1);
                    end else begin
                        m_acc[s] = t;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        if (Reset) model_reset();
        else       model_edge();
        cyc++;
        @(negedge Clock);
        check("acc_wrap",  acc_0,  m_acc[0]);
        check("ovf_wrap",  ovf_0,  m_ovf[0]);
        check("done_wrap", done_0, m_done);
        check("acc_sat",   acc_1,  m_acc[1]);
        check("ovf_sat",   ovf_1,  m_ovf[1]);
        check("done_sat",  done_1, m_done);
        if (done_0) begin
            done_count++;
            last_done_cyc = cyc;
        end
    endtask

    task automatic press(input int d, input bit sub, input int low, input int high);
        Data     = WI'(d);
        Sub      = sub;
        Enable_n = 1'b0;
        repeat (low) tick();
        Enable_n = 1'b1;
        repeat (high) tick();
    endtask

    task automatic clear_pulse();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
    endtask

    int start;

    initial begin
        Reset = 1'b1; Enable_n = 1'b1; Clear = 1'b0; Sub = 1'b0; Data = '0;
        model_reset();
        #2;
        check("rst_acc",  acc_0, 0);
        check("rst_ovf",  ovf_0, 0);
        check("rst_done", done_0, 0);
        check("rst_acc_sat", acc_1, 0);
        repeat (2) tick();
        Reset = 1'b0;

        // Three clean presses of 5
        done_count = 0;
        repeat (3) press(5, 1'b0, 10, 10);
        check("t1_acc", acc_0, 15);
        check("t1_ovf", ovf_0, 0);
        check("t1_done_count", done_count, 3);

        // Glitch of 3 cycles is ignored; 4 cycles is one update at edge k+5
        done_count = 0;
        press(9, 1'b0, 3, 10);
        check("t2_glitch_done", done_count, 0);
        check("t2_glitch_acc", acc_0, 15);
        start = cyc;
        press(9, 1'b0, 4, 10);
        check("t2_done_count", done_count, 1);
        check("t2_latency", last_done_cyc - (start + 1), DB + 1);
        check("t2_acc", acc_0, 24);

        // Preset 1020 then overflow
        clear_pulse();
        repeat (4) press(255, 1'b0, 6, 6);
        check("t3_preset", acc_0, 1020);
        press(8, 1'b0, 6, 6);
        check("t3_wrap_acc", acc_0, 4);
        check("t3_wrap_ovf", ovf_0, 1);
        check("t3_sat_acc", acc_1, 1023);
        check("t3_sat_ovf", ovf_1, 1);
        press(1, 1'b0, 6, 6);
        check("t3_sticky_acc", acc_0, 5);
        check("t3_sticky_ovf", ovf_0, 1);

        // Borrow: 3 - 5
        clear_pulse();
        check("t4_clear_ovf", ovf_1, 0);
        press(3, 1'b0, 6, 6);
        press(5, 1'b1, 6, 6);
        check("t4_sat_acc", acc_1, 0);
        check("t4_sat_ovf", ovf_1, 1);
        check("t4_wrap_acc", acc_0, 1022);

        // Clear on the update edge discards the press
        clear_pulse();
        press(7, 1'b0, 6, 6);
        check("t5_pre_acc", acc_0, 7);
        Data = 8'd2; Sub = 1'b0; Enable_n = 1'b0;
        done_count = 0;
        repeat (5) tick();
        clear_pulse();
        repeat (10) tick();
        check("t5_done_count", done_count, 0);
        check("t5_acc", acc_0, 0);
        check("t5_ovf", ovf_0, 0);
        Enable_n = 1'b1;
        repeat (8) tick();

        // Reset mid-debounce with the button held
        press(4, 1'b0, 6, 6);
        Enable_n = 1'b0;
        repeat (4) tick();
        Reset = 1'b1;
        #1;
        check("t6_rst_acc", acc_0, 0);
        check("t6_rst_acc_sat", acc_1, 0);
        check("t6_rst_ovf", ovf_0, 0);
        check("t6_rst_done", done_0, 0);
        model_reset();
        tick();
        Reset = 1'b0;
        done_count = 0;
        start = cyc;
        repeat (10) tick();
        check("t6_done_count", done_count, 1);
        check("t6_latency", last_done_cyc - start, DB + 2);
        check("t6_acc", acc_0, 4);
        Enable_n = 1'b1;
        repeat (8) tick();

        // Randomised presses, operands and clears
        repeat (60) begin
            Clear    = ($urandom_range(0, 9) == 0);
            Data     = WI'($urandom);
            Sub      = 1'($urandom);
            Enable_n = 1'b0;
            repeat ($urandom_range(1, 8)) tick();
            Clear    = 1'b0;
            Enable_n = 1'b1;
            repeat ($urandom_range(1, 10)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
